seq_capture_player: RTL and testbench

SEQ_CAPTURE_PLAYER -- requirements
Module: seq_capture_player

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_timer.sv | 27 ++
 rtl/seq_capture_player.sv | 184 ++++++++++++++++++
 tb/tb_seq_capture_player.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and widths for the sequence capture/playback block.
// Pointers address up to SEQ_DEPTH_MAX entries; lengths need one extra bit to hold the full count.
package seq_pkg;
    localparam int SEQ_DEPTH_MAX = 16;
    localparam int PTR_W         = $clog2(SEQ_DEPTH_MAX);
    localparam int LEN_W         = PTR_W + 1;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHOW,
        ST_BLANK,
        ST_DONE
    } seq_state_t;
endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with terminal-count flag, used for the HOLD and GAP phases.
// Latency: count visible the cycle after load; tc is combinational on the count.
// No backpressure: load has priority over en; the counter holds at zero.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/seq_capture_player.sv
// Captures len consecutive LFSR values, then replays each for HOLD cycles followed by GAP blank cycles.
// Latency: first element shown len+1 cycles after start; done pulses at 1+len+len*(HOLD+GAP). No backpressure.
// SEQ_NONZERO_EN: zero samples are skipped during capture (LFSR keeps advancing).
module seq_capture_player #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 4,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] seq_len,
    input  logic [2:0] rnd,
    output logic       lfsr_en,
    output logic [2:0] show,
    output logic       show_valid,
    output logic       busy,
    output logic       done
);
    import seq_pkg::*;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_L   = CNT_W'(GAP - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_len_req;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [2:0]       r_mem [SEQ_DEPTH_MAX];
    logic [2:0]       w_rd_dat;
    logic             w_wr_en;
    logic             w_sample_ok;
    logic             w_last_wr;
    logic             w_last_rd;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_tc;

    logic             r_lfsr_en;
    logic [2:0]       r_show;
    logic             r_show_valid;
    logic             r_busy;
    logic             r_done;

    assign w_len_req = (LEN_W'(seq_len) > DEPTH_L) ? DEPTH_L : LEN_W'(seq_len);
    assign w_last_wr = ({1'b0, r_wr_ptr} == (r_len - LEN_W'(1)));
    assign w_last_rd = ({1'b0, r_rd_ptr} == (r_len - LEN_W'(1)));

`ifdef SEQ_NONZERO_EN
    assign w_sample_ok = (rnd != 3'b000);
`else
    assign w_sample_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_en      = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && (seq_len != 4'd0)) begin
                    w_state_nxt = ST_CAPTURE;
                    w_len_nxt   = w_len_req;
                end
            end
            ST_CAPTURE: begin
                if (w_sample_ok) begin
                    w_wr_en      = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (w_last_wr) begin
                        w_state_nxt  = ST_SHOW;
                        w_rd_ptr_nxt = '0;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = HOLD_L;
                    end
                end
            end
            ST_SHOW: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    w_state_nxt = ST_BLANK;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GAP_L;
                end
            end
            ST_BLANK: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    if (w_last_rd) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_SHOW;
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = HOLD_L;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt = ST_IDLE;
        end

        // Every path back to IDLE (done, abort, stray state) starts the next run from a clean slate.
        if (w_state_nxt == ST_IDLE) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_wr_en      = 1'b0;
            w_tmr_load   = 1'b1;
            w_tmr_val    = '0;
        end
    end

    // The first element may be written on the same edge it is first shown (len=1).
    assign w_rd_dat = (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) ? rnd : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= rnd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_lfsr_en    <= 1'b0;
            r_show       <= '0;
            r_show_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_lfsr_en    <= (w_state_nxt == ST_CAPTURE);
            r_show       <= (w_state_nxt == ST_SHOW) ? w_rd_dat : 3'd0;
            r_show_valid <= (w_state_nxt == ST_SHOW);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_tc       (w_tmr_tc)
    );

    assign lfsr_en    = r_lfsr_en;
    assign show       = r_show;
    assign show_valid = r_show_valid;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_seq_capture_player.sv
// Directed bench for seq_capture_player: each run is checked cycle by cycle against an expected timeline.
module tb_seq_capture_player;
    localparam int TB_DEPTH = 8;
    localparam int TB_HOLD  = 4;
    localparam int TB_GAP   = 2;
`ifdef SEQ_NONZERO_EN
    localparam bit NZ = 1'b1;
`else
    localparam bit NZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] seq_len;
    logic [2:0] rnd;
    logic       lfsr_en;
    logic [2:0] show;
    logic       show_valid;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;
    logic [2:0] feed [32];

    always #5 clk = ~clk;

    seq_capture_player #(
        .DEPTH (TB_DEPTH),
        .HOLD  (TB_HOLD),
        .GAP   (TB_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seq_len    (seq_len),
        .rnd        (rnd),
        .lfsr_en    (lfsr_en),
        .show       (show),
        .show_valid (show_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " lfsr_en"}, {7'd0, lfsr_en}, 8'd0);
        chk({tag, " show"}, {5'd0, show}, 8'd0);
        chk({tag, " show_valid"}, {7'd0, show_valid}, 8'd0);
        chk({tag, " busy"}, {7'd0, busy}, 8'd0);
        chk({tag, " done"}, {7'd0, done}, 8'd0);
    endtask

    // Starts a run in the current cycle (cycle 0) and checks every output from cycle 1 onward.
    task automatic run_case(input string tag, input int req_len, input int abort_cyc, input int stray_cyc);
        int eff, cap, nst, doneat, last, k;
        logic [2:0] vals [16];
        logic       e_lfsr, e_busy, e_done, e_sv;
        logic [2:0] e_show;
        for (int i = 0; i < 16; i++) vals[i] = 3'd0;
        eff = (req_len > TB_DEPTH) ? TB_DEPTH : req_len;
        nst = 0;
        cap = 0;
        for (int i = 0; i < 32 && nst < eff; i++) begin
            if (!(NZ && feed[i] == 3'd0)) begin
                vals[nst] = feed[i];
                nst++;
            end
            cap = i + 1;
        end
        doneat = 1 + cap + eff * (TB_HOLD + TB_GAP);
        last   = (abort_cyc >= 0) ? abort_cyc + 3 : doneat + 2;
        start   = 1'b1;
        seq_len = req_len[3:0];
        for (int c = 1; c <= last; c++) begin
            tick();
            start = (c == stray_cyc);
            abort = (c == abort_cyc);
            rnd   = (c <= cap) ? feed[c-1] : 3'd2;
            e_lfsr = (c <= cap);
            e_busy = (c <= doneat);
            e_done = (c == doneat);
            e_sv   = 1'b0;
            e_show = 3'd0;
            if (c > cap && c < doneat) begin
                k = c - cap - 1;
                if ((k % (TB_HOLD + TB_GAP)) < TB_HOLD) begin
                    e_sv   = 1'b1;
                    e_show = vals[k / (TB_HOLD + TB_GAP)];
                end
            end
            if (abort_cyc >= 0 && c > abort_cyc) begin
                e_lfsr = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_sv   = 1'b0;
                e_show = 3'd0;
            end
            chk($sformatf("%s c%0d lfsr_en", tag, c), {7'd0, lfsr_en}, {7'd0, e_lfsr});
            chk($sformatf("%s c%0d show", tag, c), {5'd0, show}, {5'd0, e_show});
            chk($sformatf("%s c%0d show_valid", tag, c), {7'd0, show_valid}, {7'd0, e_sv});
            chk($sformatf("%s c%0d busy", tag, c), {7'd0, busy}, {7'd0, e_busy});
            chk($sformatf("%s c%0d done", tag, c), {7'd0, done}, {7'd0, e_done});
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        seq_len = 4'd0;
        rnd     = 3'd0;
        for (int i = 0; i < 32; i++) feed[i] = 3'd1;
        #3;
        chk_idle_outputs("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // len=3: 5,3,7 shown at cycles 4-7, 10-13, 16-19; done at 22.
        feed[0] = 3'd5; feed[1] = 3'd3; feed[2] = 3'd7;
        run_case("r033", 3, -1, -1);

        // seq_len=0 is ignored.
        start = 1'b1; seq_len = 4'd0;
        tick();
        start = 1'b0;
        chk_idle_outputs("len0 c1");
        tick();
        chk_idle_outputs("len0 c2");

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; seq_len = 4'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle_outputs("startabort c1");
        tick();
        chk_idle_outputs("startabort c2");

        // seq_len=12 clips to DEPTH=8.
        feed[0] = 3'd1; feed[1] = 3'd2; feed[2] = 3'd3; feed[3] = 3'd4;
        feed[4] = 3'd5; feed[5] = 3'd6; feed[6] = 3'd7; feed[7] = 3'd3;
        feed[8] = 3'd6; feed[9] = 3'd6; feed[10] = 3'd6; feed[11] = 3'd6;
        run_case("r034", 12, -1, -1);

        // abort during the second SHOW cycle (SHOW starts at cycle 3).
        feed[0] = 3'd6; feed[1] = 3'd1;
        run_case("r035", 2, 4, -1);

        // stray start during SHOW changes nothing.
        feed[0] = 3'd2; feed[1] = 3'd7; feed[2] = 3'd4;
        run_case("r038", 3, -1, 5);

        // zero samples: skipped with SEQ_NONZERO_EN, stored otherwise.
        feed[0] = 3'd0; feed[1] = 3'd4; feed[2] = 3'd0; feed[3] = 3'd6;
        run_case("r036", 2, -1, -1);

        // single-element sequence.
        feed[0] = 3'd5;
        run_case("len1", 1, -1, -1);

        // asynchronous reset in the middle of CAPTURE.
        start = 1'b1; seq_len = 4'd4; rnd = 3'd1;
        tick();
        start = 1'b0;
        chk({"rst_mid pre lfsr_en"}, {7'd0, lfsr_en}, 8'd1);
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk_idle_outputs("rst_mid async");
        #2;
        reset = 1'b1;
        tick();
        chk_idle_outputs("rst_mid released");
        feed[0] = 3'd3; feed[1] = 3'd5;
        run_case("r037", 2, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
